// File: rtl/uart_pkg.sv
// Shared register map, bit indices, FSM encodings and the parity helper
// used by buffered_uart and its FIFOs.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_STAT  = 2'd1;
    localparam logic [1:0] ADDR_DIVLO = 2'd2;
    localparam logic [1:0] ADDR_DIVHI = 2'd3;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_NOTFULL  = 1;
    localparam int ST_OVERRUN     = 2;
    localparam int ST_PARITY_ERR  = 3;
    localparam int ST_FRAMING_ERR = 4;
    localparam int ST_TX_IDLE     = 5;

    localparam int CT_RX_IE    = 0;
    localparam int CT_TX_IE    = 1;
    localparam int CT_ERR_IE   = 2;
    localparam int CT_PAR_EN   = 3;
    localparam int CT_PAR_ODD  = 4;
    localparam int CT_ERR_CLR  = 7;
    localparam int CTRL_W      = 5;

    // Oversampling: 16 ticks per bit, start bit re-checked at its middle.
    localparam logic [3:0] SUB_LAST  = 4'd15;
    localparam logic [3:0] START_MID = 4'd7;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1).
    function automatic logic parity_bit(input logic [7:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// A push while full only lands if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wptr_r == rptr_r);
    assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign head      = mem_r[rptr_r[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (do_push_s) wptr_r <= wptr_r + (AW+1)'(1);
            if (do_pop_s)  rptr_r <= rptr_r + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wptr_r[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/buffered_uart.sv
// CPU-attached UART with negative-true byte bus, 16x baud divisor,
// RX/TX FIFOs, optional parity, sticky error flags and maskable interrupt.
module buffered_uart
    import uart_pkg::*;
#(
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter int          STOP_BITS  = 1,
    parameter logic [15:0] DIV_RESET  = 16'd26
) (
    input  logic       CLK,
    input  logic       NRESET,
    input  logic [1:0] ADDR,
    input  logic       NCS,
    input  logic       NO,
    input  logic       NW,
    inout  wire  [7:0] data,
    output logic       NINT,
    input  logic       RX,
    output logic       TX
);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    logic                 wr_s, rd_s, rd0_s, wr_commit_s;
    logic                 wr_prev_r, rd0_prev_r;
    logic                 err_clr_s, div_wr_s, tx_push_s, rx_pop_s;
    logic [CTRL_W-1:0]    ctrl_r;
    logic [15:0]          div_r, baud_cnt_r;
    logic                 tick_s;
    logic                 overrun_r, parity_err_r, framing_err_r;
    logic [7:0]           status_s, rd_data_s, rx_bus_word_s;
    logic                 nint_r, tx_r;

    logic                 rx_meta_r, rx_sync_r;
    rx_state_t            rx_state_r, rx_state_next_s;
    logic [3:0]           rx_sub_r;
    logic [2:0]           rx_bits_r;
    logic [DATA_BITS-1:0] rx_shift_r, rx_head_s;
    logic [7:0]           rx_word_s;
    logic                 rx_bit_end_s, rx_push_s, rx_par_fail_s, rx_frame_fail_s, rx_overrun_s;
    logic                 rx_full_s, rx_empty_s;

    tx_state_t            tx_state_r, tx_state_next_s;
    logic [3:0]           tx_sub_r;
    logic [2:0]           tx_bits_r;
    logic [DATA_BITS-1:0] tx_data_r, tx_head_s;
    logic [7:0]           tx_word_s;
    logic                 tx_bit_end_s, tx_pop_s, tx_line_s, tx_full_s, tx_empty_s;

    assign wr_s        = !NCS && !NW;
    assign rd_s        = !NCS && !NO;
    assign rd0_s       = rd_s && (ADDR == ADDR_DATA);
    assign wr_commit_s = wr_s && !wr_prev_r;
    assign err_clr_s   = wr_commit_s && (ADDR == ADDR_STAT) && data[CT_ERR_CLR];
    assign div_wr_s    = wr_commit_s && ADDR[1];
    assign tx_push_s   = wr_commit_s && (ADDR == ADDR_DATA);
    // The RX head is consumed only once the CPU has finished reading it.
    assign rx_pop_s    = rd0_prev_r && !rd0_s && !rx_empty_s;

    // Bus access history for write edge detection and end-of-read pop
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            wr_prev_r  <= 1'b0;
            rd0_prev_r <= 1'b0;
        end else begin
            wr_prev_r  <= wr_s;
            rd0_prev_r <= rd0_s;
        end
    end

    // Control and divisor registers
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            ctrl_r <= '0;
            div_r  <= DIV_RESET;
        end else if (wr_commit_s) begin
            case (ADDR)
                ADDR_STAT:  ctrl_r      <= data[CTRL_W-1:0];
                ADDR_DIVLO: div_r[7:0]  <= data;
                ADDR_DIVHI: div_r[15:8] <= data;
                default:    ;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle still sets its flag
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            overrun_r     <= 1'b0;
            parity_err_r  <= 1'b0;
            framing_err_r <= 1'b0;
        end else begin
            overrun_r     <= (overrun_r && !err_clr_s) || rx_overrun_s;
            parity_err_r  <= (parity_err_r && !err_clr_s) || rx_par_fail_s;
            framing_err_r <= (framing_err_r && !err_clr_s) || rx_frame_fail_s;
        end
    end

    assign tick_s = (baud_cnt_r == div_r);

    // Baud counter: period divisor+1, restarted by any divisor write
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET)               baud_cnt_r <= 16'd0;
        else if (div_wr_s || tick_s) baud_cnt_r <= 16'd0;
        else                       baud_cnt_r <= baud_cnt_r + 16'd1;
    end

    // Two-flop synchroniser for the asynchronous RX pin
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_bit_end_s = tick_s && (rx_sub_r == SUB_LAST);

    // RX state register
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) rx_state_r <= RX_IDLE;
        else         rx_state_r <= rx_state_next_s;
    end

    // RX next-state logic
    always_comb begin
        rx_state_next_s = rx_state_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (tick_s && !rx_sync_r) rx_state_next_s = RX_START;
                else                      rx_state_next_s = RX_IDLE;
            end
            RX_START: begin
                if (tick_s && (rx_sub_r == START_MID)) rx_state_next_s = rx_sync_r ? RX_IDLE : RX_DATA;
                else                                   rx_state_next_s = RX_START;
            end
            RX_DATA: begin
                if (rx_bit_end_s && (rx_bits_r == LAST_DATA))
                    rx_state_next_s = ctrl_r[CT_PAR_EN] ? RX_PARITY : RX_STOP;
                else
                    rx_state_next_s = RX_DATA;
            end
            RX_PARITY: begin
                if (rx_bit_end_s) rx_state_next_s = RX_STOP;
                else              rx_state_next_s = RX_PARITY;
            end
            RX_STOP: begin
                if (rx_bit_end_s) rx_state_next_s = RX_IDLE;
                else              rx_state_next_s = RX_STOP;
            end
            default: rx_state_next_s = RX_IDLE;
        endcase
    end

    // RX outputs: push at mid-stop, parity/framing checks, overrun
    always_comb begin
        rx_word_s                  = 8'h00;
        rx_word_s[DATA_BITS-1:0]   = rx_shift_r;
        rx_push_s       = (rx_state_r == RX_STOP) && rx_bit_end_s;
        rx_frame_fail_s = rx_push_s && !rx_sync_r;
        rx_par_fail_s   = (rx_state_r == RX_PARITY) && rx_bit_end_s &&
                          (rx_sync_r != parity_bit(rx_word_s, ctrl_r[CT_PAR_ODD]));
        rx_overrun_s    = rx_push_s && rx_full_s && !rx_pop_s;
    end

    // RX tick/bit counters and shift register
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            rx_sub_r   <= 4'd0;
            rx_bits_r  <= 3'd0;
            rx_shift_r <= '0;
        end else begin
            if (rx_state_next_s != rx_state_r) rx_sub_r <= 4'd0;
            else if (tick_s)                   rx_sub_r <= rx_sub_r + 4'd1;
            if (rx_state_next_s != rx_state_r) rx_bits_r <= 3'd0;
            else if (rx_bit_end_s)             rx_bits_r <= rx_bits_r + 3'd1;
            if ((rx_state_r == RX_DATA) && rx_bit_end_s)
                rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
        end
    end

    assign tx_bit_end_s = tick_s && (tx_sub_r == SUB_LAST);
    assign tx_pop_s     = (tx_state_next_s == TX_START) && (tx_state_r != TX_START);

    // TX state register
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) tx_state_r <= TX_IDLE;
        else         tx_state_r <= tx_state_next_s;
    end

    // TX next-state logic; STOP chains straight into START when more data waits
    always_comb begin
        tx_state_next_s = tx_state_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (!tx_empty_s) tx_state_next_s = TX_START;
                else             tx_state_next_s = TX_IDLE;
            end
            TX_START: begin
                if (tx_bit_end_s) tx_state_next_s = TX_DATA;
                else              tx_state_next_s = TX_START;
            end
            TX_DATA: begin
                if (tx_bit_end_s && (tx_bits_r == LAST_DATA))
                    tx_state_next_s = ctrl_r[CT_PAR_EN] ? TX_PARITY : TX_STOP;
                else
                    tx_state_next_s = TX_DATA;
            end
            TX_PARITY: begin
                if (tx_bit_end_s) tx_state_next_s = TX_STOP;
                else              tx_state_next_s = TX_PARITY;
            end
            TX_STOP: begin
                if (tx_bit_end_s && (tx_bits_r == LAST_STOP))
                    tx_state_next_s = tx_empty_s ? TX_IDLE : TX_START;
                else
                    tx_state_next_s = TX_STOP;
            end
            default: tx_state_next_s = TX_IDLE;
        endcase
    end

    // TX line level for the current state
    always_comb begin
        tx_word_s                = 8'h00;
        tx_word_s[DATA_BITS-1:0] = tx_data_r;
        case (tx_state_r)
            TX_IDLE:   tx_line_s = 1'b1;
            TX_START:  tx_line_s = 1'b0;
            TX_DATA:   tx_line_s = tx_data_r[tx_bits_r];
            TX_PARITY: tx_line_s = parity_bit(tx_word_s, ctrl_r[CT_PAR_ODD]);
            TX_STOP:   tx_line_s = 1'b1;
            default:   tx_line_s = 1'b1;
        endcase
    end

    // TX counters and the word being shifted out
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            tx_sub_r  <= 4'd0;
            tx_bits_r <= 3'd0;
            tx_data_r <= '0;
        end else begin
            if (tx_state_next_s != tx_state_r) tx_sub_r <= 4'd0;
            else if (tick_s)                   tx_sub_r <= tx_sub_r + 4'd1;
            if (tx_state_next_s != tx_state_r) tx_bits_r <= 3'd0;
            else if (tx_bit_end_s)             tx_bits_r <= tx_bits_r + 3'd1;
            if (tx_pop_s) tx_data_r <= tx_head_s;
        end
    end

    // Registered serial output and interrupt
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            tx_r   <= 1'b1;
            nint_r <= 1'b1;
        end else begin
            tx_r   <= tx_line_s;
            nint_r <= !((ctrl_r[CT_RX_IE] && !rx_empty_s) ||
                        (ctrl_r[CT_TX_IE] && tx_empty_s) ||
                        (ctrl_r[CT_ERR_IE] && (overrun_r || parity_err_r || framing_err_r)));
        end
    end

    assign TX   = tx_r;
    assign NINT = nint_r;

    // Status word and read-data mux
    always_comb begin
        status_s                     = 8'h00;
        status_s[ST_RX_NONEMPTY]     = !rx_empty_s;
        status_s[ST_TX_NOTFULL]      = !tx_full_s;
        status_s[ST_OVERRUN]         = overrun_r;
        status_s[ST_PARITY_ERR]      = parity_err_r;
        status_s[ST_FRAMING_ERR]     = framing_err_r;
        status_s[ST_TX_IDLE]         = tx_empty_s && (tx_state_r == TX_IDLE);
        rx_bus_word_s                = 8'h00;
        rx_bus_word_s[DATA_BITS-1:0] = rx_head_s;
        case (ADDR)
            ADDR_DATA:  rd_data_s = rx_empty_s ? 8'h00 : rx_bus_word_s;
            ADDR_STAT:  rd_data_s = status_s;
            ADDR_DIVLO: rd_data_s = div_r[7:0];
            ADDR_DIVHI: rd_data_s = div_r[15:8];
            default:    rd_data_s = 8'h00;
        endcase
    end

    assign data = rd_s ? rd_data_s : 8'bzzzz_zzzz;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (CLK),
        .rst_n (NRESET),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .wdata (rx_shift_r),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .head  (rx_head_s)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (CLK),
        .rst_n (NRESET),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .wdata (data[DATA_BITS-1:0]),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .head  (tx_head_s)
    );

endmodule

// File: tb/tb_buffered_uart.sv
// Directed bench for buffered_uart: register vector table plus hand-written
// serial sequences for TX timing, loopback parity, overrun, framing and glitches.
module tb_buffered_uart;
    logic       CLK = 1'b0;
    logic       NRESET;
    logic [1:0] ADDR;
    logic       NCS, NO, NW;
    logic [7:0] tb_dout;
    logic       tb_oe;
    logic       rx_drive;
    logic       loop_en;
    wire  [7:0] data_w;
    wire        rx_w;
    wire        TX, NINT;
    int         n_cmp = 0;
    int         n_fail = 0;

    assign data_w = tb_oe ? tb_dout : 8'bzzzz_zzzz;
    assign rx_w   = loop_en ? TX : rx_drive;

    always #5 CLK = ~CLK;

    buffered_uart dut (
        .CLK    (CLK),
        .NRESET (NRESET),
        .ADDR   (ADDR),
        .NCS    (NCS),
        .NO     (NO),
        .NW     (NW),
        .data   (data_w),
        .NINT   (NINT),
        .RX     (rx_w),
        .TX     (TX)
    );

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wval;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
        @(negedge CLK);
        ADDR = a; tb_dout = v; tb_oe = 1'b1; NCS = 1'b0; NW = 1'b0;
        @(negedge CLK);
        NW = 1'b1; NCS = 1'b1; tb_oe = 1'b0;
        @(negedge CLK);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
        @(negedge CLK);
        ADDR = a; NCS = 1'b0; NO = 1'b0;
        #2;
        v = data_w;
        @(negedge CLK);
        NO = 1'b1; NCS = 1'b1;
        @(negedge CLK);
    endtask

    // Frame at 16 clocks per bit (divisor 0), 8 data bits, no parity.
    task automatic send_frame(input logic [7:0] v, input logic stop_v);
        rx_drive = 1'b0;
        repeat (16) @(negedge CLK);
        for (int b = 0; b < 8; b++) begin
            rx_drive = v[b];
            repeat (16) @(negedge CLK);
        end
        rx_drive = stop_v;
        repeat (16) @(negedge CLK);
        rx_drive = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs [10];
        logic [7:0] rd;
        logic [7:0] exp_v;
        logic       tx_exp [10];
        int         len;

        vecs[0] = '{1'b0, 2'd1, 8'h00, 8'h22};
        vecs[1] = '{1'b0, 2'd2, 8'h00, 8'h1A};
        vecs[2] = '{1'b0, 2'd3, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 2'd0, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 2'd3, 8'h12, 8'h12};
        vecs[5] = '{1'b1, 2'd2, 8'h34, 8'h34};
        vecs[6] = '{1'b1, 2'd1, 8'h07, 8'h22};
        vecs[7] = '{1'b1, 2'd3, 8'h00, 8'h00};
        vecs[8] = '{1'b1, 2'd2, 8'h00, 8'h00};
        vecs[9] = '{1'b1, 2'd1, 8'h00, 8'h22};
        tx_exp  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        NRESET = 1'b0; ADDR = 2'd0; NCS = 1'b1; NO = 1'b1; NW = 1'b1;
        tb_dout = 8'h00; tb_oe = 1'b0; rx_drive = 1'b1; loop_en = 1'b0;
        repeat (3) @(negedge CLK);
        NRESET = 1'b1;
        @(negedge CLK);

        check("reset_tx", {7'd0, TX}, 8'h01);
        check("reset_nint", {7'd0, NINT}, 8'h01);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wval);
            bus_read(vecs[i].addr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // TX of 8'hA5 at divisor 0
        bus_write(2'd0, 8'hA5);
        for (int i = 0; i < 50 && TX !== 1'b0; i++) @(negedge CLK);
        check("tx_start_seen", {7'd0, TX}, 8'h00);
        len = 0;
        for (int i = 0; i < 40 && TX === 1'b0; i++) begin
            len++;
            @(negedge CLK);
        end
        check("tx_start_len", 8'(len), 8'd16);
        repeat (7) @(negedge CLK);
        for (int b = 1; b < 10; b++) begin
            check($sformatf("tx_bit%0d", b), {7'd0, TX}, {7'd0, tx_exp[b]});
            if (b < 9) repeat (16) @(negedge CLK);
        end
        for (int i = 0; i < 20; i++) begin
            bus_read(2'd1, rd);
            if (rd[5]) break;
        end
        check("tx_idle_after", rd, 8'h22);

        // Loopback with odd parity
        bus_write(2'd1, 8'h18);
        loop_en = 1'b1;
        bus_write(2'd0, 8'h3C);
        rd = 8'h00;
        for (int i = 0; i < 120; i++) begin
            bus_read(2'd1, rd);
            if (rd[0]) break;
        end
        check("loop_arrive", {7'd0, rd[0]}, 8'h01);
        repeat (20) @(negedge CLK);
        bus_read(2'd1, rd);
        check("loop_status", rd, 8'h23);
        bus_read(2'd0, rd);
        check("loop_data", rd, 8'h3C);
        bus_read(2'd1, rd);
        check("loop_popped", rd, 8'h22);
        loop_en = 1'b0;
        bus_write(2'd1, 8'h00);

        // 17 frames into a 16-deep RX FIFO
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b1);
        repeat (20) @(negedge CLK);
        bus_read(2'd1, rd);
        check("ovr_status", rd, 8'h27);
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, rd);
            exp_v = 8'h10 + 8'(i);
            check($sformatf("ovr_data%0d", i), rd, exp_v);
        end
        bus_read(2'd1, rd);
        check("ovr_drained", rd, 8'h26);
        bus_write(2'd1, 8'h80);
        bus_read(2'd1, rd);
        check("ovr_cleared", rd, 8'h22);

        // Stop bit forced low
        send_frame(8'h55, 1'b0);
        repeat (20) @(negedge CLK);
        bus_read(2'd1, rd);
        check("frm_status", rd, 8'h33);
        check("frm_nint_masked", {7'd0, NINT}, 8'h01);
        bus_write(2'd1, 8'h04);
        check("frm_nint_err", {7'd0, NINT}, 8'h00);
        bus_read(2'd0, rd);
        check("frm_data", rd, 8'h55);
        bus_write(2'd1, 8'h80);
        bus_read(2'd1, rd);
        check("frm_cleared", rd, 8'h22);
        check("frm_nint_clear", {7'd0, NINT}, 8'h01);

        // Two-clock glitch with rx_ie set and RX FIFO empty
        bus_write(2'd1, 8'h01);
        check("gl_nint_before", {7'd0, NINT}, 8'h01);
        rx_drive = 1'b0;
        repeat (2) @(negedge CLK);
        rx_drive = 1'b1;
        repeat (40) @(negedge CLK);
        bus_read(2'd1, rd);
        check("gl_status", rd, 8'h22);
        bus_read(2'd0, rd);
        check("gl_data", rd, 8'h00);
        check("gl_nint_after", {7'd0, NINT}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
